// File: rtl/scr1_tcm_loader.sv
// scr1_tcm_loader: turns a framed boot byte stream into sequential TCM port-B word writes.
// Define SCR1_TCM_LOADER_CSUM_EN to require a trailing 8-bit checksum byte after the data.
module scr1_tcm_loader #(
  parameter int unsigned SCR1_WIDTH     = 32,
  parameter int unsigned SCR1_SIZE      = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         mem_wenb,
  output logic [3:0]                   mem_webb,
  output logic [$clog2(SCR1_SIZE)-3:0] mem_addrb,
  output logic [SCR1_WIDTH-1:0]        mem_datab,
  output logic                         core_rst_hold,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned AW  = $clog2(SCR1_SIZE) - 2;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CAP = SCR1_SIZE / 4;

  // IDLE/LEN1: length bytes | DATA: word assembly | CSUM: check byte | DONE/ERR: terminal
  typedef enum logic [2:0] {S_IDLE, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;

`ifdef SCR1_TCM_LOADER_CSUM_EN
  localparam state_e S_AFTER_DATA = S_CSUM;
  logic [7:0] sum_q, sum_d;
`else
  localparam state_e S_AFTER_DATA = S_DONE;
`endif

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]         word_idx_q, word_idx_d;
  logic [SCR1_WIDTH-1:0] word_q, word_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_wenb_q, mem_wenb_d;
  logic [3:0]            mem_webb_q, mem_webb_d;
  logic [AW-1:0]         mem_addrb_q, mem_addrb_d;
  logic [SCR1_WIDTH-1:0] mem_datab_q, mem_datab_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        accept;
  logic        active;
  logic [15:0] len_rx;
  logic        last_word;

  always_comb begin
    accept    = in_valid & in_ready_q;
    active    = state_q inside {S_LEN1, S_DATA, S_CSUM};
    len_rx    = {in_data, len_lo_q};
    last_word = (16'(word_idx_q) == (len_q - 16'd1));

    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    word_d      = word_q;
    mem_wenb_d  = 1'b0;
    mem_addrb_d = mem_addrb_q;
    mem_datab_d = mem_datab_q;
`ifdef SCR1_TCM_LOADER_CSUM_EN
    sum_d       = sum_q;
`endif

    // Idle-gap timer: reloaded by every byte, ERR when it hits zero inside a frame
    tmr_d = tmr_q;
    if (accept) begin
      tmr_d = TW'(TIMEOUT_CYCLES - 1);
    end else if (active && (tmr_q != '0)) begin
      tmr_d = tmr_q - TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d      = len_rx;
          word_idx_d = '0;
          byte_cnt_d = '0;
`ifdef SCR1_TCM_LOADER_CSUM_EN
          sum_d      = 8'h00;
`endif
          if (len_rx == 16'd0) begin
            state_d = S_AFTER_DATA;
          end else if (32'(len_rx) > CAP) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[8*byte_cnt_q +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef SCR1_TCM_LOADER_CSUM_EN
          sum_d      = sum_q + in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_wenb_d  = 1'b1;
            mem_addrb_d = word_idx_q;
            mem_datab_d = word_d;
            if (last_word) begin
              state_d = S_AFTER_DATA;
            end else begin
              word_idx_d = word_idx_q + AW'(1);
            end
          end
        end
      end
`ifdef SCR1_TCM_LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = ((sum_q + in_data) == 8'd0) ? S_DONE : S_ERR;
        end
      end
`endif
      default: ;
    endcase

    if (active && !accept && (tmr_q == '0)) begin
      state_d = S_ERR;
    end

    in_ready_d = !(state_d inside {S_DONE, S_ERR});
    mem_webb_d = mem_wenb_d ? 4'hF : 4'h0;
    // Leaving DATA straight to DONE: hold done back a cycle so it follows the final write
    done_d     = done_q | ((state_d == S_DONE) && (state_q != S_DATA));
    err_d      = err_q | (state_d == S_ERR);
    hold_d     = ~done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      word_q      <= '0;
      tmr_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_wenb_q  <= 1'b0;
      mem_webb_q  <= 4'h0;
      mem_addrb_q <= '0;
      mem_datab_q <= '0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SCR1_TCM_LOADER_CSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      word_q      <= word_d;
      tmr_q       <= tmr_d;
      in_ready_q  <= in_ready_d;
      mem_wenb_q  <= mem_wenb_d;
      mem_webb_q  <= mem_webb_d;
      mem_addrb_q <= mem_addrb_d;
      mem_datab_q <= mem_datab_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SCR1_TCM_LOADER_CSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_wenb      = mem_wenb_q;
  assign mem_webb      = mem_webb_q;
  assign mem_addrb     = mem_addrb_q;
  assign mem_datab     = mem_datab_q;
  assign core_rst_hold = hold_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_scr1_tcm_loader.sv
// Bench for scr1_tcm_loader: directed and random frames scored against a frame-level model.
// Follows SCR1_TCM_LOADER_CSUM_EN the same way the design does.
module tb_scr1_tcm_loader;

  localparam int TO  = 16;
  localparam int CAP = 16384;
`ifdef SCR1_TCM_LOADER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_wenb;
  logic [3:0]  mem_webb;
  logic [13:0] mem_addrb;
  logic [31:0] mem_datab;
  logic        core_rst_hold;
  logic        done;
  logic        err;

  scr1_tcm_loader #(.SCR1_WIDTH(32), .SCR1_SIZE(32'h0001_0000), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wenb(mem_wenb), .mem_webb(mem_webb), .mem_addrb(mem_addrb), .mem_datab(mem_datab),
    .core_rst_hold(core_rst_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miscmp = 0;
  int cyc = 0;

  logic [7:0] frame_q[$];
  int         acc_q[$];
  int         wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int         wr_cyc_q[$];
  int         done_cyc = -1;
  int         err_cyc = -1;
  int         webb_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (mem_wenb) begin
        wr_addr_q.push_back(int'(mem_addrb));
        wr_data_q.push_back(mem_datab);
        wr_cyc_q.push_back(cyc);
        if (mem_webb != 4'hF) webb_bad++;
      end else if (mem_webb != 4'h0) begin
        webb_bad++;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (err && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic clear_obs();
    acc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc = -1;
    err_cyc  = -1;
    webb_bad = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_vals", {in_ready, mem_wenb, mem_webb, mem_addrb, mem_datab, core_rst_hold, done, err},
        64'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    @(negedge clk);
    chk("rdy_pre_edge", in_ready, 1'b0);
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Offer each byte, optionally after a random idle gap; stop once a byte is refused
  task automatic send_frame(input int max_gap);
    bit taken;
    foreach (frame_q[i]) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = frame_q[i];
      taken = 1'b0;
      for (int k = 0; k < 4 && !taken; k++) begin
        @(negedge clk);
        taken = in_ready;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!taken) break;
    end
  endtask

  task automatic wait_end();
    for (int k = 0; k < 40 && !(done || err); k++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] neg_sum();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 2; i < frame_q.size(); i++) s = s + frame_q[i];
    return 8'h00 - s;
  endfunction

  // Frame-level reference: what should have been accepted, written and concluded
  task automatic check_frame();
    int n, nacc, nw, exp_cyc, last;
    bit bad_len, complete, exp_ok;
    logic [7:0] s;
    logic [31:0] w;
    n = {frame_q[1], frame_q[0]};
    bad_len = (n > CAP);
    if (bad_len) nacc = 2;
    else nacc = 2 + 4 * n + CS;
    complete = (frame_q.size() >= nacc);
    if (!complete) nacc = frame_q.size();
    nw = bad_len ? 0 : (((nacc - 2) / 4 < n) ? (nacc - 2) / 4 : n);
    exp_ok = complete && !bad_len;
    if (exp_ok && CS == 1) begin
      s = 8'h00;
      for (int i = 2; i < nacc; i++) s = s + frame_q[i];
      exp_ok = (s == 8'h00);
    end
    last = (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : 0;
    if (!complete && !bad_len) exp_cyc = last + TO + 1;
    else if (bad_len || CS == 1 || n == 0) exp_cyc = last + 1;
    else exp_cyc = last + 2;

    chk("accepted", acc_q.size(), nacc);
    chk("writes", wr_addr_q.size(), nw);
    for (int j = 0; j < nw && j < wr_addr_q.size(); j++) begin
      w = {frame_q[2+4*j+3], frame_q[2+4*j+2], frame_q[2+4*j+1], frame_q[2+4*j]};
      chk("wr_addr", wr_addr_q[j], j);
      chk("wr_data", wr_data_q[j], w);
      if (2 + 4 * j + 3 < acc_q.size()) chk("wr_lat", wr_cyc_q[j], acc_q[2+4*j+3] + 1);
    end
    chk("done", done, exp_ok);
    chk("err", err, !exp_ok);
    chk("hold", core_rst_hold, !exp_ok);
    chk("rdy_terminal", in_ready, 1'b0);
    chk("end_cycle", exp_ok ? done_cyc : err_cyc, exp_cyc);
    chk("webb", webb_bad, 0);
  endtask

  task automatic run(input int max_gap);
    send_frame(max_gap);
    wait_end();
    check_frame();
  endtask

  initial begin
    int n;
    logic [7:0] c;

    do_reset();
    frame_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef SCR1_TCM_LOADER_CSUM_EN
    frame_q.push_back(neg_sum());
`endif
    run(0);

    do_reset();
    frame_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
    run(0);
    do_reset();
    frame_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF7};
    run(0);

    do_reset();
    frame_q = '{8'h01, 8'h40, 8'h00, 8'h00};
    run(0);
    do_reset();
    frame_q = '{8'hFF, 8'hFF, 8'h11};
    run(0);

    do_reset();
    frame_q = '{8'h01, 8'h00, 8'hAA};
    run(0);

    do_reset();
    repeat (3 * TO) begin @(posedge clk); #1; end
    chk("idle_no_timeout", {err, in_ready}, 2'b01);
    frame_q = '{8'h00, 8'h00};
`ifdef SCR1_TCM_LOADER_CSUM_EN
    frame_q.push_back(8'h00);
`endif
    frame_q.push_back(8'h55);
    run(0);

    do_reset();
    frame_q = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_frame(0);
    do_reset();
    frame_q = '{8'h01, 8'h00, 8'hC4, 8'hB3, 8'hA2, 8'h91};
`ifdef SCR1_TCM_LOADER_CSUM_EN
    frame_q.push_back(neg_sum());
`endif
    run(0);

    for (int r = 0; r < 16; r++) begin
      do_reset();
      n = (r % 5 == 4) ? 0 : int'($urandom_range(6, 1));
      frame_q.delete();
      frame_q.push_back(8'(n));
      frame_q.push_back(8'(n >> 8));
      for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
`ifdef SCR1_TCM_LOADER_CSUM_EN
      c = neg_sum();
      if ($urandom_range(3, 0) == 0) c = c + 8'h01;
      frame_q.push_back(c);
`else
      c = 8'($urandom);
      if ($urandom_range(1, 0) == 1) frame_q.push_back(c);
`endif
      run(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
